// File: rtl/serial_adder_engine.sv
// Digit-serial add/subtract engine: one shared DIGIT-bit adder slice walks
// the operands LSB-first and delivers sum, carry-out and signed overflow
// behind valid/ready handshakes on both sides.
module serial_adder_engine #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder_engine: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb, res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   slc;
  logic [WIDTH-1:0] res_nxt;
  logic             slc_ovf;

  // Accept only from IDLE, and never while reset is asserted.
  assign in_ready = (state == IDLE) && !rst;

  // Shared adder slice on the low digit; its result enters the top of the
  // result shift register. Overflow uses the equivalent sign test: the MSB
  // inputs agree but the MSB result differs (carry-in xor carry-out of MSB).
  always_comb begin
    slc     = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    res_nxt = WIDTH'({slc[DIGIT-1:0], res} >> DIGIT);
    slc_ovf = (opa[DIGIT-1] == opb[DIGIT-1]) && (slc[DIGIT-1] != opa[DIGIT-1]);
  end

  // Control FSM plus datapath; sum/cout/ovf only change on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + ~borrow.
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ^ cin;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          res   <= res_nxt;
          carry <= slc[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NDIG - 1)) begin
            sum       <= res_nxt;
            cout      <= slc[DIGIT];
            ovf       <= slc_ovf;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_engine.sv
// Directed + randomized bench for serial_adder_engine against an
// arithmetic reference model (integer add/sub, range-checked overflow).
module tb_serial_adder_engine;
  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout, ovf, busy;

  // 8-bit sweep pair: bit-serial and single-cycle slice, driven identically.
  logic       iv8, ord8, cin8, sub8;
  logic [7:0] a8, b8;
  logic       ir_d1, ov_d1, co_d1, of_d1, bz_d1;
  logic       ir_d8, ov_d8, co_d8, of_d8, bz_d8;
  logic [7:0] s_d1, s_d8;

  int checks = 0;
  int errors = 0;

  serial_adder_engine #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy));

  serial_adder_engine #(.WIDTH(8), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir_d1),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ov_d1),
    .out_ready(ord8), .sum(s_d1), .cout(co_d1), .ovf(of_d1), .busy(bz_d1));

  serial_adder_engine #(.WIDTH(8), .DIGIT(8)) dut_d8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir_d8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ov_d8),
    .out_ready(ord8), .sum(s_d8), .cout(co_d8), .ovf(of_d8), .busy(bz_d8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce modulo 2^32.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                       input logic ms, output logic [31:0] s, output logic co,
                       output logic ov);
    longint ua, ub, sa, sb, c, u, r;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    c  = mc ? 64'sd1 : 64'sd0;
    if (ms) begin
      u  = ua - ub - c;
      r  = sa - sb - c;
      co = (u >= 0);
    end else begin
      u  = ua + ub + c;
      r  = sa + sb + c;
      co = (u >= 64'sd4294967296);
    end
    s  = 32'(u);
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endtask

  // One full transaction; hold = cycles of out_ready low once DONE is seen.
  task automatic op32(input logic [31:0] ta, input logic [31:0] tb2, input logic tc,
                      input logic ts, input int hold);
    logic [31:0] es;
    logic        eco, eov;
    int          lat;
    model(ta, tb2, tc, ts, es, eco, eov);
    chk1("pre_in_ready", in_ready, 1'b1);
    a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    chk1("run_in_ready", in_ready, 1'b0);
    chk1("run_busy", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk32("latency", 32'(lat), 32'd8);
    chk32("sum", sum, es);
    chk1("cout", cout, eco);
    chk1("ovf", ovf, eov);
    for (int i = 0; i < hold; i++) begin
      a = $urandom; b = $urandom; in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk1("hold_valid", out_valid, 1'b1);
      chk1("hold_in_ready", in_ready, 1'b0);
      chk32("hold_sum", sum, es);
      chk1("hold_cout", cout, eco);
      chk1("hold_ovf", ovf, eov);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("post_valid", out_valid, 1'b0);
    chk1("post_in_ready", in_ready, 1'b1);
    chk1("post_busy", busy, 1'b0);
  endtask

  // Drive both 8-bit engines together and check latency and result.
  task automatic sweep8(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                        input logic ts, input logic [7:0] es, input logic eco,
                        input logic eov);
    int lat1, lat8;
    chk1("sw_ready_d1", ir_d1, 1'b1);
    chk1("sw_ready_d8", ir_d8, 1'b1);
    a8 = ta; b8 = tb2; cin8 = tc; sub8 = ts; iv8 = 1'b1; ord8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat1 = -1; lat8 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ov_d1 && lat1 < 0) begin
        lat1 = c;
        chk32("sw_sum_d1", 32'(s_d1), 32'(es));
        chk1("sw_cout_d1", co_d1, eco);
        chk1("sw_ovf_d1", of_d1, eov);
      end
      if (ov_d8 && lat8 < 0) begin
        lat8 = c;
        chk32("sw_sum_d8", 32'(s_d8), 32'(es));
        chk1("sw_cout_d8", co_d8, eco);
        chk1("sw_ovf_d8", of_d8, eov);
      end
    end
    chk32("sw_lat_d1", 32'(lat1), 32'd8);
    chk32("sw_lat_d8", 32'(lat8), 32'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'h1; b = 32'h1; cin = 1'b0; sub = 1'b0;
    iv8 = 1'b0; ord8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

    // Reset held 3 cycles with in_valid high: reset must win.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk1("rst_in_ready", in_ready, 1'b0);
    end
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_sum", sum, 32'h0);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk1("rel_in_ready", in_ready, 1'b1);

    // Directed arithmetic cases.
    op32(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 0);
    chk32("d_wrap_sum", sum, 32'h0);
    chk1("d_wrap_cout", cout, 1'b1);
    op32(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 0);
    chk32("d_ovf_sum", sum, 32'h80000000);
    chk1("d_ovf_ovf", ovf, 1'b1);
    op32(32'd5, 32'd7, 1'b0, 1'b1, 0);
    chk32("d_sub_sum", sum, 32'hFFFFFFFE);
    chk1("d_sub_cout", cout, 1'b0);
    op32(32'h80000000, 32'h1, 1'b0, 1'b1, 0);
    chk32("d_subov_sum", sum, 32'h7FFFFFFF);
    chk1("d_subov_ovf", ovf, 1'b1);
    op32(32'd10, 32'd3, 1'b1, 1'b1, 0);
    chk32("d_borrow_sum", sum, 32'd6);
    chk1("d_borrow_cout", cout, 1'b1);

    // Backpressure, then a follow-up operation.
    op32(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0, 5);
    op32(32'd1, 32'd2, 1'b0, 1'b0, 0);
    chk32("d_bp_next_sum", sum, 32'd3);

    // Reset in the middle of RUN aborts the operation.
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk1("abort_rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk32("abort_no_valid", 32'(seen), 32'd0);
    op32(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0);
    chk32("d_after_abort_sum", sum, 32'h23456789);

    // Randomized operations with random backpressure.
    for (int i = 0; i < 24; i++)
      op32($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    op32(32'h0, 32'h0, 1'b1, 1'b1, 0);
    op32(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1);

    // Parameter sweep at WIDTH=8.
    sweep8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    sweep8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
